// File: rtl/buffer_b_pingpong.sv
// buffer_b_pingpong: two-bank ping-pong buffer built on one simple-dual-port RAM.
// A loader fills the bank selected by wr_sel while a consumer ("mm") drains
// the bank selected by rd_sel. Bank ownership is handed over with
// load_done / mm_done pulses.
//
// Optional build macro: BUFFER_B_PINGPONG_ERR_EN
//   When defined, an extra output 'err' appears. It goes high and stays high
//   after any dropped write, dropped read, or ignored done pulse, and only
//   reset clears it. Without the macro these drops are silent.
//
// Timing summary:
//   write : accepted write is held one cycle, committed on the next edge
//   read  : data appears 4 cycles after an accepted read (input reg,
//           2 RAM cycles, output reg), one read per cycle
module buffer_b_pingpong #(
  parameter int    BUFFER_ADDR_WIDTH  = 9,
  parameter int    BUFFER_DATA_WIDTH  = 512,
  parameter string MEM_POOL_PRIMITIVE = "auto"
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_write_addr_valid,
  input  logic [BUFFER_ADDR_WIDTH-1:0] load_write_addr,
  input  logic [BUFFER_DATA_WIDTH-1:0] load_write_data,
  input  logic                         load_done,
  output logic                         load_ready,
  input  logic                         mm_read_addr_valid,
  input  logic [BUFFER_ADDR_WIDTH-1:0] mm_read_addr,
  input  logic                         mm_done,
  output logic                         mm_ready,
  output logic                         mm_read_data_valid,
  output logic [BUFFER_DATA_WIDTH-1:0] mm_read_data
`ifdef BUFFER_B_PINGPONG_ERR_EN
  ,
  output logic                         err
`endif
);

  // Physical RAM address is {bank, word address}.
  localparam int PHYS_AW = BUFFER_ADDR_WIDTH + 1;
  localparam int DEPTH   = 1 << PHYS_AW;

  typedef enum logic {
    BANK_FREE   = 1'b0,
    BANK_LOADED = 1'b1
  } bank_state_t;

  // Per-bank ownership and the two bank pointers.
  bank_state_t bank_state_reg [0:1];
  logic        wr_sel_reg;
  logic        rd_sel_reg;

  // Accepted-transaction strobes.
  logic write_accept;
  logic load_done_accept;
  logic read_accept;
  logic mm_done_accept;

  // Write staging register (one cycle between accept and RAM commit).
  logic                         wr_pend_reg;
  logic [PHYS_AW-1:0]           wr_addr_reg;
  logic [BUFFER_DATA_WIDTH-1:0] wr_data_reg;

  // Read pipeline: address register, two RAM stages, output register.
  logic                         rd_pend_reg;
  logic [PHYS_AW-1:0]           rd_addr_reg;
  logic                         ram_v1_reg;
  logic                         ram_v2_reg;
  logic [BUFFER_DATA_WIDTH-1:0] ram_q1_reg;
  logic [BUFFER_DATA_WIDTH-1:0] ram_q2_reg;
  logic                         out_valid_reg;
  logic [BUFFER_DATA_WIDTH-1:0] out_data_reg;

  // Readiness comes purely from registered state, so there is no
  // combinational path from any input to load_ready / mm_ready.
  assign load_ready = (bank_state_reg[wr_sel_reg] == BANK_FREE);
  assign mm_ready   = (bank_state_reg[rd_sel_reg] == BANK_LOADED);

  assign write_accept     = load_write_addr_valid & load_ready;
  assign load_done_accept = load_done & load_ready;
  assign read_accept      = mm_read_addr_valid & mm_ready;
  assign mm_done_accept   = mm_done & mm_ready;

  // Each bank becomes LOADED when the loader hands it over and FREE when
  // the consumer releases it. An accepted load_done always targets a FREE
  // bank and an accepted mm_done a LOADED one, so both can fire in the same
  // cycle without ever touching the same bank.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      // Ownership state of bank gi.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bank_state_reg[gi] <= BANK_FREE;
        end else if (load_done_accept && (wr_sel_reg == 1'(gi))) begin
          bank_state_reg[gi] <= BANK_LOADED;
        end else if (mm_done_accept && (rd_sel_reg == 1'(gi))) begin
          bank_state_reg[gi] <= BANK_FREE;
        end
      end
    end
  endgenerate

  // Fill and drain pointers flip after each accepted hand-over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_reg <= 1'b0;
      rd_sel_reg <= 1'b0;
    end else begin
      if (load_done_accept) begin
        wr_sel_reg <= ~wr_sel_reg;
      end
      if (mm_done_accept) begin
        rd_sel_reg <= ~rd_sel_reg;
      end
    end
  end

  // Stage an accepted write. The bank is captured now, so a write arriving
  // together with load_done still lands in the bank being handed over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_reg <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_pend_reg <= write_accept;
      if (write_accept) begin
        wr_addr_reg <= {wr_sel_reg, load_write_addr};
        wr_data_reg <= load_write_data;
      end
    end
  end

  // Register an accepted read with the drain bank captured at accept time.
  // Reads issued together with mm_done therefore still read the released bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_reg <= 1'b0;
      rd_addr_reg <= '0;
    end else begin
      rd_pend_reg <= read_accept;
      if (read_accept) begin
        rd_addr_reg <= {rd_sel_reg, mm_read_addr};
      end
    end
  end

  // RAM storage. The primitive hint only steers the synthesis mapping; every
  // variant has the same read-first, two-cycle read behaviour.
  generate
    if (MEM_POOL_PRIMITIVE == "ultra") begin : g_ram_ultra
      (* ram_style = "ultra" *) logic [BUFFER_DATA_WIDTH-1:0] mem [0:DEPTH-1];
      // Write port and first read stage (read-first on collision).
      always_ff @(posedge clk) begin
        if (wr_pend_reg) begin
          mem[wr_addr_reg] <= wr_data_reg;
        end
        if (rd_pend_reg) begin
          ram_q1_reg <= mem[rd_addr_reg];
        end
      end
    end else if (MEM_POOL_PRIMITIVE == "b") begin : g_ram_block
      (* ram_style = "block" *) logic [BUFFER_DATA_WIDTH-1:0] mem [0:DEPTH-1];
      // Write port and first read stage (read-first on collision).
      always_ff @(posedge clk) begin
        if (wr_pend_reg) begin
          mem[wr_addr_reg] <= wr_data_reg;
        end
        if (rd_pend_reg) begin
          ram_q1_reg <= mem[rd_addr_reg];
        end
      end
    end else if (MEM_POOL_PRIMITIVE == "d") begin : g_ram_dist
      (* ram_style = "distributed" *) logic [BUFFER_DATA_WIDTH-1:0] mem [0:DEPTH-1];
      // Write port and first read stage (read-first on collision).
      always_ff @(posedge clk) begin
        if (wr_pend_reg) begin
          mem[wr_addr_reg] <= wr_data_reg;
        end
        if (rd_pend_reg) begin
          ram_q1_reg <= mem[rd_addr_reg];
        end
      end
    end else begin : g_ram_auto
      logic [BUFFER_DATA_WIDTH-1:0] mem [0:DEPTH-1];
      // Write port and first read stage (read-first on collision).
      always_ff @(posedge clk) begin
        if (wr_pend_reg) begin
          mem[wr_addr_reg] <= wr_data_reg;
        end
        if (rd_pend_reg) begin
          ram_q1_reg <= mem[rd_addr_reg];
        end
      end
    end
  endgenerate

  // Second RAM stage (output register of the RAM primitive), no reset so it
  // can be absorbed into the memory macro.
  always_ff @(posedge clk) begin
    ram_q2_reg <= ram_q1_reg;
  end

  // Valid bits travel alongside the RAM stages; data output is forced to
  // zero whenever it is not qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_v1_reg    <= 1'b0;
      ram_v2_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      ram_v1_reg    <= rd_pend_reg;
      ram_v2_reg    <= ram_v1_reg;
      out_valid_reg <= ram_v2_reg;
      out_data_reg  <= ram_v2_reg ? ram_q2_reg : '0;
    end
  end

  assign mm_read_data_valid = out_valid_reg;
  assign mm_read_data       = out_data_reg;

`ifdef BUFFER_B_PINGPONG_ERR_EN
  logic err_reg;
  logic err_event;

  assign err_event = (load_write_addr_valid & ~load_ready) |
                     (load_done             & ~load_ready) |
                     (mm_read_addr_valid    & ~mm_ready)   |
                     (mm_done               & ~mm_ready);

  // Sticky protocol-error flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (err_event) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_buffer_b_pingpong.sv
// Testbench for buffer_b_pingpong: directed scenarios plus random traffic
// checked against a behavioural bank/ownership model.
// Optional build macro: BUFFER_B_PINGPONG_ERR_EN (checks the err output).
module tb_buffer_b_pingpong;

  localparam int AW   = 9;
  localparam int DW   = 512;
  localparam int WPB  = 1 << AW;     // words per bank
  localparam int MAXC = 4096;        // log depth in cycles

  logic          clk;
  logic          rst_n;
  logic          load_write_addr_valid;
  logic [AW-1:0] load_write_addr;
  logic [DW-1:0] load_write_data;
  logic          load_done;
  logic          load_ready;
  logic          mm_read_addr_valid;
  logic [AW-1:0] mm_read_addr;
  logic          mm_done;
  logic          mm_ready;
  logic          mm_read_data_valid;
  logic [DW-1:0] mm_read_data;
`ifdef BUFFER_B_PINGPONG_ERR_EN
  logic          err;
`endif

  buffer_b_pingpong #(
    .BUFFER_ADDR_WIDTH (AW),
    .BUFFER_DATA_WIDTH (DW),
    .MEM_POOL_PRIMITIVE("auto")
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .load_write_addr_valid(load_write_addr_valid),
    .load_write_addr      (load_write_addr),
    .load_write_data      (load_write_data),
    .load_done            (load_done),
    .load_ready           (load_ready),
    .mm_read_addr_valid   (mm_read_addr_valid),
    .mm_read_addr         (mm_read_addr),
    .mm_done              (mm_done),
    .mm_ready             (mm_ready),
    .mm_read_data_valid   (mm_read_data_valid),
    .mm_read_data         (mm_read_data)
`ifdef BUFFER_B_PINGPONG_ERR_EN
    ,
    .err                  (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;
  int cyc;

  // Behavioural model: bank ownership, pointers, bank contents.
  logic          m_loaded [0:1];
  logic          m_wsel;
  logic          m_rsel;
  logic [DW-1:0] m_mem   [0:2*WPB-1];
  logic          m_known [0:2*WPB-1];
  logic          m_err;

  // Expected/observed per-cycle logs (index = cycles since start).
  logic          exp_valid [0:MAXC-1];
  logic          exp_known [0:MAXC-1];
  logic [DW-1:0] exp_data  [0:MAXC-1];
  logic          exp_lr    [0:MAXC-1];
  logic          exp_mr    [0:MAXC-1];
  logic          obs_valid [0:MAXC-1];
  logic [DW-1:0] obs_data  [0:MAXC-1];
  logic          obs_lr    [0:MAXC-1];
  logic          obs_mr    [0:MAXC-1];

  function automatic logic [DW-1:0] pat(input int b, input int a);
    logic [31:0] w;
    w = 32'h0A5A_0000 | (32'(b) << 28) | 32'(a);
    return {16{w}};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < DW / 32; i++) v = {v[DW-33:0], $urandom()};
    return v;
  endfunction

  function automatic void model_reset();
    m_loaded[0] = 1'b0;
    m_loaded[1] = 1'b0;
    m_wsel = 1'b0;
    m_rsel = 1'b0;
    m_err  = 1'b0;
    for (int i = 0; i < 2 * WPB; i++) m_known[i] = 1'b0;
    for (int i = cyc + 1; i < MAXC; i++) exp_valid[i] = 1'b0;
  endfunction

  // Applies one cycle of inputs (called at the falling edge), advances the
  // model by one clock, and logs the DUT outputs seen just after the edge.
  task automatic drive_cycle(input logic wv, input int wa, input logic [DW-1:0] wd,
                             input logic ld, input logic rv, input int ra, input logic md);
    logic lr_ok, mr_ok, old_w, old_r;
    int   p;
    load_write_addr_valid = wv;
    load_write_addr       = AW'(wa);
    load_write_data       = wd;
    load_done             = ld;
    mm_read_addr_valid    = rv;
    mm_read_addr          = AW'(ra);
    mm_done               = md;
    exp_lr[cyc] = !m_loaded[m_wsel];
    exp_mr[cyc] = m_loaded[m_rsel];
    obs_lr[cyc] = load_ready;
    obs_mr[cyc] = mm_ready;
    lr_ok = rst_n && !m_loaded[m_wsel];
    mr_ok = rst_n && m_loaded[m_rsel];
    if (rst_n) begin
      if (wv && lr_ok) begin
        p = int'(m_wsel) * WPB + wa;
        m_mem[p]   = wd;
        m_known[p] = 1'b1;
      end
      if (rv && mr_ok) begin
        p = int'(m_rsel) * WPB + ra;
        exp_valid[cyc + 4] = 1'b1;
        exp_data[cyc + 4]  = m_mem[p];
        exp_known[cyc + 4] = m_known[p];
      end
      if ((wv || ld) && !lr_ok) m_err = 1'b1;
      if ((rv || md) && !mr_ok) m_err = 1'b1;
      old_w = m_wsel;
      old_r = m_rsel;
      if (ld && lr_ok) begin
        m_loaded[old_w] = 1'b1;
        m_wsel = !old_w;
      end
      if (md && mr_ok) begin
        m_loaded[old_r] = 1'b0;
        m_rsel = !old_r;
      end
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    cyc++;
    obs_valid[cyc] = mm_read_data_valid;
    obs_data[cyc]  = mm_read_data;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle(2);
    if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready: got %b want 1", load_ready); end
    if (mm_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mm_ready: got %b want 0", mm_ready); end
    if (mm_read_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", mm_read_data_valid); end
    if (mm_read_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", mm_read_data); end
    n_cmp += 4;
    rst_n = 1'b1;
    idle(2);
    if (load_ready !== 1'b1 || mm_ready !== 1'b0 || mm_read_data_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got lr=%b mr=%b v=%b want 1 0 0", load_ready, mm_ready, mm_read_data_valid);
    end
    n_cmp++;
`ifdef BUFFER_B_PINGPONG_ERR_EN
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++;
`endif
  endtask

  task automatic test_basic();
    int t;
    drive_cycle(1'b1, 5, 512'hA5, 1'b0, 1'b0, 0, 1'b0);
    drive_cycle(1'b0, 0, '0, 1'b1, 1'b0, 0, 1'b0);
    if (load_ready !== 1'b1 || mm_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_handover: got lr=%b mr=%b want 1 1", load_ready, mm_ready);
    end
    n_cmp++;
    t = cyc;
    drive_cycle(1'b0, 0, '0, 1'b0, 1'b1, 5, 1'b0);
    idle(6);
    if (obs_valid[t + 3] !== 1'b0 || obs_valid[t + 5] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid_window: got v@3=%b v@5=%b want 0 0", obs_valid[t + 3], obs_valid[t + 5]);
    end
    if (obs_valid[t + 4] !== 1'b1) begin n_fail++; $display("FAIL basic_latency4_valid: got %b want 1", obs_valid[t + 4]); end
    if (obs_data[t + 4] !== 512'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", obs_data[t + 4]); end
    n_cmp += 3;
  endtask

  task automatic test_full_and_back_to_back();
    int t, run;
    do_reset();
    for (int a = 0; a < 16; a++) drive_cycle(1'b1, a, pat(0, a), a == 15, 1'b0, 0, 1'b0);
    for (int a = 0; a < 16; a++) drive_cycle(1'b1, a, pat(1, a), a == 15, 1'b0, 0, 1'b0);
    if (load_ready !== 1'b0 || mm_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready: got lr=%b mr=%b want 0 1", load_ready, mm_ready);
    end
    n_cmp++;
    for (int a = 0; a < 4; a++) drive_cycle(1'b1, a, pat(2, a), 1'b0, 1'b0, 0, 1'b0);
    idle(2);
    t = cyc;
    for (int a = 0; a < 16; a++) drive_cycle(1'b0, 0, '0, 1'b0, 1'b1, a, 1'b0);
    idle(6);
    run = 0;
    for (int c = t + 1; c <= cyc; c++) if (obs_valid[c] === 1'b1) run++;
    if (run != 16) begin n_fail++; $display("FAIL b2b_valid_count: got %0d want 16", run); end
    if (obs_valid[t + 3] !== 1'b0 || obs_valid[t + 20] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_valid_edges: got %b %b want 0 0", obs_valid[t + 3], obs_valid[t + 20]);
    end
    n_cmp += 2;
    for (int i = 0; i < 16; i++) begin
      if (obs_valid[t + 4 + i] !== 1'b1 || obs_data[t + 4 + i] !== pat(0, i)) begin
        n_fail++;
        $display("FAIL b2b_data[%0d]: got v=%b %h want 1 %h", i, obs_valid[t + 4 + i], obs_data[t + 4 + i], pat(0, i));
      end
      n_cmp++;
    end
  endtask

  task automatic test_simultaneous_done();
    int t;
    // Release bank0 so one bank is free and the other loaded.
    drive_cycle(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b1);
    if (load_ready !== 1'b1 || mm_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_pre: got lr=%b mr=%b want 1 1", load_ready, mm_ready);
    end
    n_cmp++;
    drive_cycle(1'b1, 7, 512'h77, 1'b1, 1'b0, 0, 1'b1);
    if (load_ready !== 1'b1 || mm_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_swap: got lr=%b mr=%b want 1 1", load_ready, mm_ready);
    end
    n_cmp++;
    t = cyc;
    drive_cycle(1'b0, 0, '0, 1'b0, 1'b1, 7, 1'b0);
    drive_cycle(1'b1, 9, 512'h99, 1'b1, 1'b0, 0, 1'b0);
    if (load_ready !== 1'b0) begin n_fail++; $display("FAIL simul_both_loaded: got lr=%b want 0", load_ready); end
    n_cmp++;
    idle(4);
    if (obs_valid[t + 4] !== 1'b1 || obs_data[t + 4] !== 512'h77) begin
      n_fail++;
      $display("FAIL simul_read_bank0: got v=%b %h want 1 77", obs_valid[t + 4], obs_data[t + 4]);
    end
    n_cmp++;
    drive_cycle(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b1);
    t = cyc;
    drive_cycle(1'b0, 0, '0, 1'b0, 1'b1, 9, 1'b1);
    if (load_ready !== 1'b1 || mm_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_drained: got lr=%b mr=%b want 1 0", load_ready, mm_ready);
    end
    n_cmp++;
    idle(5);
    if (obs_valid[t + 4] !== 1'b1 || obs_data[t + 4] !== 512'h99) begin
      n_fail++;
      $display("FAIL simul_read_released_bank: got v=%b %h want 1 99", obs_valid[t + 4], obs_data[t + 4]);
    end
    n_cmp++;
  endtask

  task automatic test_drop_read();
    int t;
    if (mm_ready !== 1'b0) begin n_fail++; $display("FAIL drop_pre: got mr=%b want 0", mm_ready); end
    n_cmp++;
    t = cyc;
    drive_cycle(1'b0, 0, '0, 1'b0, 1'b1, 7, 1'b0);
    drive_cycle(1'b0, 0, '0, 1'b0, 1'b0, 0, 1'b1);
    idle(6);
    for (int c = t + 1; c <= cyc; c++) begin
      if (obs_valid[c] !== 1'b0 || obs_data[c] !== '0) begin
        n_fail++;
        $display("FAIL drop_read_out@%0d: got v=%b %h want 0 0", c - t, obs_valid[c], obs_data[c]);
      end
      n_cmp++;
    end
    if (mm_ready !== 1'b0) begin n_fail++; $display("FAIL drop_mm_done_ignored: got mr=%b want 0", mm_ready); end
    n_cmp++;
`ifdef BUFFER_B_PINGPONG_ERR_EN
    if (err !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b want 1", err); end
    idle(3);
    if (err !== 1'b1) begin n_fail++; $display("FAIL drop_err_sticky: got %b want 1", err); end
    n_cmp += 2;
`endif
  endtask

  task automatic test_random();
    int start;
    start = cyc;
    for (int i = 0; i < 500; i++) begin
      drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 31), rand_word(),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 31), $urandom_range(0, 9) == 0);
    end
    idle(6);
    for (int c = start; c < cyc; c++) begin
      if (obs_lr[c] !== exp_lr[c] || obs_mr[c] !== exp_mr[c]) begin
        n_fail++;
        $display("FAIL rand_ready@%0d: got lr=%b mr=%b want %b %b", c, obs_lr[c], obs_mr[c], exp_lr[c], exp_mr[c]);
      end
      n_cmp++;
    end
    for (int c = start + 1; c <= cyc; c++) begin
      if (obs_valid[c] !== exp_valid[c]) begin
        n_fail++;
        $display("FAIL rand_valid@%0d: got %b want %b", c, obs_valid[c], exp_valid[c]);
      end else if (exp_valid[c] && exp_known[c] && obs_data[c] !== exp_data[c]) begin
        n_fail++;
        $display("FAIL rand_data@%0d: got %h want %h", c, obs_data[c], exp_data[c]);
      end else if (!exp_valid[c] && obs_data[c] !== '0) begin
        n_fail++;
        $display("FAIL rand_idle_data@%0d: got %h want 0", c, obs_data[c]);
      end
      n_cmp++;
    end
`ifdef BUFFER_B_PINGPONG_ERR_EN
    if (err !== m_err) begin n_fail++; $display("FAIL rand_err: got %b want %b", err, m_err); end
    n_cmp++;
`endif
  endtask

  task automatic test_reset_inflight();
    int t;
    do_reset();
    for (int a = 0; a < 3; a++) drive_cycle(1'b1, a, pat(3, a), a == 2, 1'b0, 0, 1'b0);
    t = cyc;
    for (int a = 0; a < 3; a++) drive_cycle(1'b0, 0, '0, 1'b0, 1'b1, a, 1'b0);
    rst_n = 1'b0;
    #1;
    if (mm_read_data_valid !== 1'b0 || mm_read_data !== '0) begin
      n_fail++;
      $display("FAIL inflight_async_out: got v=%b %h want 0 0", mm_read_data_valid, mm_read_data);
    end
    if (load_ready !== 1'b1 || mm_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_async_ready: got lr=%b mr=%b want 1 0", load_ready, mm_ready);
    end
    n_cmp += 2;
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(7);
    for (int c = t + 3; c <= cyc; c++) begin
      if (obs_valid[c] !== 1'b0 || obs_data[c] !== '0) begin
        n_fail++;
        $display("FAIL inflight_flushed@%0d: got v=%b %h want 0 0", c - t, obs_valid[c], obs_data[c]);
      end
      n_cmp++;
    end
    if (load_ready !== 1'b1 || mm_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_after: got lr=%b mr=%b want 1 0", load_ready, mm_ready);
    end
    n_cmp++;
`ifdef BUFFER_B_PINGPONG_ERR_EN
    if (err !== 1'b0) begin n_fail++; $display("FAIL inflight_err: got %b want 0", err); end
    n_cmp++;
`endif
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    for (int i = 0; i < MAXC; i++) begin
      exp_valid[i] = 1'b0;
      exp_known[i] = 1'b0;
      exp_data[i]  = '0;
      obs_valid[i] = 1'b0;
      obs_data[i]  = '0;
    end
    rst_n                 = 1'b0;
    load_write_addr_valid = 1'b0;
    load_write_addr       = '0;
    load_write_data       = '0;
    load_done             = 1'b0;
    mm_read_addr_valid    = 1'b0;
    mm_read_addr          = '0;
    mm_done               = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_full_and_back_to_back();
    test_simultaneous_done();
    test_drop_read();
    test_random();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/buffer_b_pingpong.md
BUFFER_B_PINGPONG -- requirements
Module: buffer_b_pingpong

Interface
REQ-001 SHALL have parameter BUFFER_ADDR_WIDTH, default 9, word address width within one bank.
REQ-002 SHALL have parameter BUFFER_DATA_WIDTH, default 512, word width in bits.
REQ-003 SHALL have parameter MEM_POOL_PRIMITIVE, default "auto", RAM primitive select ("ultra","b","d","auto").
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load_write_addr_valid  input  1  write strobe into fill bank.
REQ-007 SHALL have port load_write_addr  input  BUFFER_ADDR_WIDTH  write word address.
REQ-008 SHALL have port load_write_data  input  BUFFER_DATA_WIDTH  write data.
REQ-009 SHALL have port load_done  input  1  pulse, fill bank complete, hand it to mm.
REQ-010 SHALL have port load_ready  output  1  fill bank free, writes accepted.
REQ-011 SHALL have port mm_read_addr_valid  input  1  read strobe from drain bank.
REQ-012 SHALL have port mm_read_addr  input  BUFFER_ADDR_WIDTH  read word address.
REQ-013 SHALL have port mm_done  input  1  pulse, drain bank consumed, release it.
REQ-014 SHALL have port mm_ready  output  1  drain bank loaded, reads accepted.
REQ-015 SHALL have port mm_read_data_valid  output  1  read data qualifier.
REQ-016 SHALL have port mm_read_data  output  BUFFER_DATA_WIDTH  read data.

Function
REQ-017 SHALL implement two banks (0,1) of 2^BUFFER_ADDR_WIDTH words in one simple-dual-port RAM, physical address {bank, addr}, RAM read latency 2.
REQ-018 SHALL keep per-bank state FREE or LOADED, a fill pointer wr_sel and a drain pointer rd_sel.
REQ-019 SHALL drive load_ready = (state[wr_sel]==FREE) and mm_ready = (state[rd_sel]==LOADED), both registered-state derived, no combinational path from inputs.
REQ-020 SHALL register an accepted write (valid & load_ready) for one cycle and commit it to bank wr_sel the next cycle: write latency 2 cycles.
REQ-021 SHALL drop writes issued while load_ready=0 with no RAM update.
REQ-022 SHALL on load_done with load_ready=1 set state[wr_sel]=LOADED and toggle wr_sel next cycle; load_done with load_ready=0 ignored.
REQ-023 SHALL accept load_done in the same cycle as the final write; that write still lands in the old wr_sel bank.
REQ-024 SHALL return read data exactly 4 cycles after an accepted read (valid & mm_ready): input register, 2 RAM cycles, output register; one read per cycle, fully pipelined.
REQ-025 SHALL drop reads issued while mm_ready=0; no valid generated.
REQ-026 SHALL drive mm_read_data to 0 whenever mm_read_data_valid=0.
REQ-027 SHALL on mm_done with mm_ready=1 set state[rd_sel]=FREE and toggle rd_sel next cycle; reads in flight complete with data from the released bank; mm_done with mm_ready=0 ignored.
REQ-028 SHALL handle load_done and mm_done in the same cycle independently (they target different banks).
REQ-029 SHALL use read_first behaviour for same-address collision; unreachable under REQ-019 legal use.

Reset
REQ-030 SHALL on rst_n=0 asynchronously clear: both banks FREE, wr_sel=0, rd_sel=0, load_ready=1, mm_ready=0, mm_read_data_valid=0, mm_read_data=0, pipeline valids 0.
REQ-031 SHALL on reset mid-operation discard in-flight reads and uncommitted writes; RAM contents undefined.

Configuration
REQ-032 SHALL compile with macro BUFFER_B_PINGPONG_ERR_EN defined: add output err (1 bit, reset 0), sticky high after any dropped write, dropped read, or ignored load_done/mm_done, cleared only by reset.
REQ-033 SHALL without BUFFER_B_PINGPONG_ERR_EN: no err port, drops silent, otherwise identical.

Verification
REQ-034 SHALL cover: after reset write addr 5=0xA5 to bank0, load_done -> load_ready=1 (bank1), mm_ready=1; read addr 5 at cycle T -> valid, data 0xA5 at T+4.
REQ-035 SHALL cover: fill bank0 and bank1 with distinct patterns, no mm_done -> load_ready=0, third-bank write dropped, bank0 reads unchanged.
REQ-036 SHALL cover: back-to-back reads addr 0..15 -> 16 consecutive valid cycles, data in order, latency 4.
REQ-037 SHALL cover: load_done and mm_done same cycle -> both pointers toggle, states swap correctly next cycle.
REQ-038 SHALL cover: read while mm_ready=0 -> no valid, data 0; with BUFFER_B_PINGPONG_ERR_EN err=1 and holds.
REQ-039 SHALL cover: rst_n low with 3 reads in flight -> valid 0 immediately, all REQ-030 values restored.
